edp_diag_reader: RTL and testbench
==================================

# edp_diag_reader

Diagnostic EBUS read sequencer: the requesting end of the EDP diagnostic-read path. A front-end request names a set of EDP sources (AR, BR, MQ, FM, BRX, ARX, ADX, AD). The block issues DIAG function 12x with the matching DIAG[4:6] code, one source at a time. It samples the 36-bit EBUS word the EDP drives and hands each word out on a valid/ready stream. It sits between the console/front-end logic and the EBUS, next to other EBUS masters.

## Interface
- SETTLE, default 2: cycles the function is held on EBUS before sampling. Legal range 1..15.
- clk  in  1  EBOX clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse. Sampled only in IDLE.
- mask  in  8  source set. Bit i requests code i: 0 AR, 1 BR, 2 MQ, 3 FM, 4 BRX, 5 ARX, 6 ADX, 7 AD.
- abort  in  1  cancel the current sequence.
- ebusBusy  in  1  another EBUS master is driving; do not start a new drive.
- ebusData  in  [0:35]  EBUS data bus.
- diagReadFunc12x  out  1  registered; asserted only in DRIVE.
- diag  out  [4:6]  registered source code. 0 whenever diagReadFunc12x is low.
- outValid  out  1  outData/outSel/outParity are valid.
- outReady  in  1  consumer accepts the word.
- outData  out  [0:35]  captured EBUS word.
- outSel  out  3  source code of outData.
- outParity  out  1  XOR of outData[0:35].
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse when a sequence completes normally.

## Operation
- States: IDLE, SELECT, DRIVE, HOLD.
- Reset: state IDLE. Every output is 0, outData is 0, the internal pending mask is 0, and the settle counter is 0.
- IDLE, start=1 with mask≠0: latch mask into pending, busy←1, go to SELECT.
- IDLE, start=1 with mask=0: pulse done on the next cycle and stay IDLE. busy stays 0 and no word is produced.
- start while busy is ignored; pending is unaffected.
- SELECT: cur ← index of the lowest set bit of pending.
  - If ebusBusy=1, stay in SELECT with diagReadFunc12x low.
  - Otherwise go to DRIVE and load the counter with SETTLE−1.
- DRIVE: diagReadFunc12x=1 and diag=cur. The counter decrements each cycle.
  - On the cycle the counter is 0: outData←ebusData, outSel←cur, outParity←^ebusData. Go to HOLD.
  - ebusBusy is ignored once in DRIVE; the bus is owned.
- HOLD: function deasserted and outValid=1. outData/outSel/outParity stay stable until the handshake.
  - On outValid&outReady: clear pending[cur] and drop outValid.
  - If the remaining pending is 0: pulse done, busy←0, go to IDLE. Otherwise go to SELECT.
- Sources are always emitted in ascending code order. Each requested source is emitted exactly once.
- abort in any non-IDLE state: next state IDLE. diagReadFunc12x, outValid and busy are 0 next cycle, pending is cleared, and there is no done pulse. abort in IDLE has no effect.
- abort outranks the outValid&outReady handshake in the same cycle: the word is not considered delivered.

## Timing
- Single-word read with start at edge 0 and ebusBusy=0:
  - SELECT in cycle 1.
  - diagReadFunc12x high in cycles 2..SETTLE+1; data captured at the end of cycle SETTLE+1.
  - outValid high from cycle SETTLE+2.
- With outReady held 1: handshake in cycle SETTLE+2 and done in cycle SETTLE+3. busy is low from cycle SETTLE+3.
- Per additional source with no stalls: SETTLE+2 cycles (SELECT + DRIVE + HOLD).
- Function is never asserted in two consecutive words without at least two deasserted cycles (HOLD, SELECT) between them.
- outReady may depend combinationally on outValid. outValid does not depend combinationally on outReady.
- Asynchronous reset mid-sequence: outputs go to 0 immediately and the sequence is discarded.

## Test plan
- SETTLE=2, mask=8'h01, EBUS=36'o123456701234, outReady=1:
  - diagReadFunc12x high in cycles 2–3 with diag=0.
  - outValid in cycle 4 with outData=36'o123456701234, outSel=0, outParity=^data.
  - done in cycle 5.
- mask=8'hFF, with a distinct EBUS pattern per code and outReady toggling 1,0,0,1…:
  - Exactly 8 words, outSel 0→7 in order.
  - Each word is held stable while outReady=0.
  - One done pulse.
- mask=8'h24 with ebusBusy=1 for 5 cycles after start:
  - The function stays low during the stall.
  - Then codes 2 and 5 are read, in that order.
- mask=8'h80, abort in the second DRIVE cycle:
  - Next cycle: diagReadFunc12x=0, busy=0, no outValid, no done.
  - A new start then works normally.
- mask=0 start → done pulse only. start during busy → no change to the sequence.
- Reset asserted while in HOLD: all outputs 0 asynchronously. After release, the block is IDLE and pending is cleared.

Source files
------------

// File: rtl/edp_diag_reader.sv
// EDP diagnostic-read sequencer: walks the requested source mask in ascending code order, drives DIAG 12x for SETTLE cycles,
// captures the EBUS word (SETTLE+2 cycles per source) and holds it on outValid until outReady; stalls in SELECT while ebusBusy.
module edp_diag_reader #(
   parameter int unsigned SETTLE = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  mask,
   input  logic        abort,
   input  logic        ebusBusy,
   input  logic [0:35] ebusData,
   output logic        diagReadFunc12x,
   output logic [4:6]  diag,
   output logic        outValid,
   input  logic        outReady,
   output logic [0:35] outData,
   output logic [2:0]  outSel,
   output logic        outParity,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SELECT, DRIVE, HOLD} state_t;

   state_t      state, state_n;
   logic [7:0]  pending, pending_n;
   logic [2:0]  cur, cur_n, low;
   logic [3:0]  cnt, cnt_n;
   logic        capture, done_n;

   always_comb begin
      low = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pending[i]) low = 3'(i);
      end
   end

   always_comb begin
      state_n   = state;
      pending_n = pending;
      cur_n     = cur;
      cnt_n     = cnt;
      capture   = 1'b0;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (mask != 8'd0) begin
                  pending_n = mask;
                  state_n   = SELECT;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         SELECT: begin
            cur_n = low;
            if (!ebusBusy) begin
               state_n = DRIVE;
               cnt_n   = 4'(SETTLE - 1);
            end
         end
         DRIVE: begin
            if (cnt == 4'd0) begin
               capture = 1'b1;
               state_n = HOLD;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         HOLD: begin
            if (outReady) begin
               pending_n = pending & ~(8'd1 << cur);
               if (pending_n == 8'd0) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  state_n = SELECT;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // Abort wins over everything, including a same-cycle handshake in HOLD.
      if (abort && state != IDLE) begin
         state_n   = IDLE;
         pending_n = 8'd0;
         done_n    = 1'b0;
         capture   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         pending         <= 8'd0;
         cur             <= 3'd0;
         cnt             <= 4'd0;
         diagReadFunc12x <= 1'b0;
         diag            <= 3'd0;
         outValid        <= 1'b0;
         outData         <= 36'd0;
         outSel          <= 3'd0;
         outParity       <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         state           <= state_n;
         pending         <= pending_n;
         cur             <= cur_n;
         cnt             <= cnt_n;
         diagReadFunc12x <= (state_n == DRIVE);
         diag            <= (state_n == DRIVE) ? cur_n : 3'd0;
         outValid        <= (state_n == HOLD);
         busy            <= (state_n != IDLE);
         done            <= done_n;
         if (capture) begin
            outData   <= ebusData;
            outSel    <= cur;
            outParity <= ^ebusData;
         end
      end
   end

endmodule

// File: tb/tb_edp_diag_reader.sv
// Bench for edp_diag_reader (SETTLE=2): per-cycle vector table plus hand sequences
// for the full-mask toggled-ready read and reset during HOLD.
module tb_edp_diag_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  mask;
   logic        abort;
   logic        ebusBusy;
   logic [0:35] ebusData;
   logic        diagReadFunc12x;
   logic [4:6]  diag;
   logic        outValid;
   logic        outReady;
   logic [0:35] outData;
   logic [2:0]  outSel;
   logic        outParity;
   logic        busy;
   logic        done;

   logic        use_pat;
   logic [35:0] tb_data;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   edp_diag_reader #(.SETTLE(2)) dut (
      .clk(clk), .reset(reset), .start(start), .mask(mask), .abort(abort),
      .ebusBusy(ebusBusy), .ebusData(ebusData),
      .diagReadFunc12x(diagReadFunc12x), .diag(diag),
      .outValid(outValid), .outReady(outReady), .outData(outData),
      .outSel(outSel), .outParity(outParity), .busy(busy), .done(done)
   );

   function automatic logic [35:0] pat(input logic [2:0] c);
      return {1'b1, c, 32'hC0DE0000 + 32'(c) * 32'h01011111};
   endfunction

   assign ebusData = use_pat ? pat(diag) : tb_data;

   typedef struct {
      logic        st;
      logic [7:0]  m;
      logic        ab;
      logic        eb;
      logic        rdy;
      logic [35:0] dat;
      logic        e_func;
      logic [2:0]  e_diag;
      logic        e_ov;
      logic [2:0]  e_sel;
      logic [35:0] e_dat;
      logic        e_busy;
      logic        e_done;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic st, input logic [7:0] m, input logic ab, input logic eb,
                               input logic rdy, input logic [35:0] dat, input logic f, input logic [2:0] dg,
                               input logic ov, input logic [2:0] sel, input logic [35:0] odat,
                               input logic bz, input logic dn);
      vec_t v;
      v.st = st; v.m = m; v.ab = ab; v.eb = eb; v.rdy = rdy; v.dat = dat;
      v.e_func = f; v.e_diag = dg; v.e_ov = ov; v.e_sel = sel; v.e_dat = odat;
      v.e_busy = bz; v.e_done = dn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [35:0] D  = 36'o123456701234;
   localparam logic [35:0] X  = 36'o707070707070;
   localparam logic [35:0] D2 = 36'o111122223333;
   localparam logic [35:0] D5 = 36'o444455556666;

   initial begin
      int n, dones, held;
      logic [35:0] hd;
      logic [2:0]  hs;
      logic        fin;

      reset = 1'b1; start = 1'b0; mask = 8'd0; abort = 1'b0; ebusBusy = 1'b0;
      outReady = 1'b0; use_pat = 1'b0; tb_data = X;
      step();
      step();
      chk("rst func", 64'(diagReadFunc12x), 64'd0);
      chk("rst diag", 64'(diag), 64'd0);
      chk("rst outValid", 64'(outValid), 64'd0);
      chk("rst outData", 64'(outData), 64'd0);
      chk("rst outSel", 64'(outSel), 64'd0);
      chk("rst outParity", 64'(outParity), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      step();

      // single word, mask 01
      vq.push_back(mk(1, 8'h01, 0, 0, 1, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 1, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 1, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, D, 0, 0, 1, 0, D, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 0, 0, 0, 0, 0, 0, 1));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 0, 0, 0, 0, 0, 0, 0));
      // empty mask: done pulse only
      vq.push_back(mk(1, 8'h00, 0, 0, 1, X, 0, 0, 0, 0, 0, 0, 1));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 0, 0, 0, 0, 0, 0, 0));
      // mask 24 with ebusBusy stall; a start mid-sequence is ignored
      vq.push_back(mk(1, 8'h24, 0, 1, 1, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 1, 1, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 1, 1, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(1, 8'h01, 0, 1, 1, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 1, 1, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 1, 1, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 1, 2, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 1, 2, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, D2, 0, 0, 1, 2, D2, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 1, 5, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 1, 5, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, D5, 0, 0, 1, 5, D5, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 0, 0, 0, 0, 0, 0, 1));
      // mask 80, abort in the second DRIVE cycle
      vq.push_back(mk(1, 8'h80, 0, 0, 1, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 1, 7, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 1, 7, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 1, 0, 1, D, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 0, 0, 0, 0, 0, 0, 0));
      // restart after abort
      vq.push_back(mk(1, 8'h80, 0, 0, 1, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 1, 7, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 1, 7, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, D, 0, 0, 1, 7, D, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 0, 0, 0, 0, 0, 0, 1));
      // abort in HOLD beats a same-cycle handshake
      vq.push_back(mk(1, 8'h01, 0, 0, 0, X, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 0, X, 1, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 0, X, 1, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 0, D2, 0, 0, 1, 0, D2, 1, 0));
      vq.push_back(mk(0, 8'h00, 1, 0, 1, X, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 8'h00, 0, 0, 1, X, 0, 0, 0, 0, 0, 0, 0));

      foreach (vq[i]) begin
         start = vq[i].st; mask = vq[i].m; abort = vq[i].ab; ebusBusy = vq[i].eb;
         outReady = vq[i].rdy; tb_data = vq[i].dat;
         step();
         chk($sformatf("r%0d func", i), 64'(diagReadFunc12x), 64'(vq[i].e_func));
         chk($sformatf("r%0d diag", i), 64'(diag), 64'(vq[i].e_diag));
         chk($sformatf("r%0d outValid", i), 64'(outValid), 64'(vq[i].e_ov));
         chk($sformatf("r%0d busy", i), 64'(busy), 64'(vq[i].e_busy));
         chk($sformatf("r%0d done", i), 64'(done), 64'(vq[i].e_done));
         if (vq[i].e_ov) begin
            chk($sformatf("r%0d outSel", i), 64'(outSel), 64'(vq[i].e_sel));
            chk($sformatf("r%0d outData", i), 64'(outData), 64'(vq[i].e_dat));
            chk($sformatf("r%0d outParity", i), 64'(outParity), 64'(^vq[i].e_dat));
         end
      end
      start = 1'b0; abort = 1'b0; ebusBusy = 1'b0;

      // full mask, per-code data, outReady pattern 1,0,0,1
      use_pat = 1'b1;
      start = 1'b1; mask = 8'hFF; outReady = 1'b0;
      step();
      start = 1'b0;
      n = 0; dones = 0; held = 0; fin = 1'b0; hd = '0; hs = '0;
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         outReady = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (held != 0) begin
            chk("ff held valid", 64'(outValid), 64'd1);
            chk("ff held data", 64'(outData), 64'(hd));
            chk("ff held sel", 64'(outSel), 64'(hs));
         end
         held = 0;
         if (outValid) begin
            if (outReady) begin
               chk($sformatf("ff w%0d sel", n), 64'(outSel), 64'(n[2:0]));
               chk($sformatf("ff w%0d data", n), 64'(outData), 64'(pat(n[2:0])));
               chk($sformatf("ff w%0d parity", n), 64'(outParity), 64'(^pat(n[2:0])));
               n++;
            end else begin
               held = 1; hd = outData; hs = 3'(n);
            end
         end
         step();
         if (done) begin
            dones++;
            fin = 1'b1;
         end
      end
      for (int k = 0; k < 4; k++) begin
         step();
         if (done) dones++;
      end
      chk("ff word count", 64'(n), 64'd8);
      chk("ff done count", 64'(dones), 64'd1);
      chk("ff busy after", 64'(busy), 64'd0);
      use_pat = 1'b0;

      // reset while in HOLD
      outReady = 1'b0; start = 1'b1; mask = 8'h01; tb_data = X;
      step();
      start = 1'b0;
      step();
      step();
      tb_data = D;
      step();
      chk("rh pre outValid", 64'(outValid), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("rh outValid", 64'(outValid), 64'd0);
      chk("rh outData", 64'(outData), 64'd0);
      chk("rh outParity", 64'(outParity), 64'd0);
      chk("rh busy", 64'(busy), 64'd0);
      chk("rh func", 64'(diagReadFunc12x), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      outReady = 1'b1;
      step();
      step();
      chk("rh idle busy", 64'(busy), 64'd0);
      chk("rh idle valid", 64'(outValid), 64'd0);
      chk("rh idle done", 64'(done), 64'd0);
      start = 1'b1; mask = 8'h02; tb_data = X;
      step();
      start = 1'b0;
      step();
      chk("rh2 diag", 64'(diag), 64'd1);
      step();
      tb_data = D5;
      step();
      chk("rh2 outValid", 64'(outValid), 64'd1);
      chk("rh2 outSel", 64'(outSel), 64'd1);
      chk("rh2 outData", 64'(outData), 64'(D5));
      step();
      chk("rh2 done", 64'(done), 64'd1);
      chk("rh2 busy", 64'(busy), 64'd0);
      step();
      chk("rh2 done end", 64'(done), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
